// File: rtl/newhope_pkg.sv
// Shared NewHope datapath constants: modulus, ring size and Barrett reduction factors.
package newhope_pkg;

  localparam int unsigned Q             = 12289;
  localparam int unsigned N             = 512;
  localparam int unsigned ADDR_W        = 9;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned COEF_W        = 14;
  localparam int unsigned BARRETT_K     = 349496;  // floor(2^32 / Q)
  localparam int unsigned BARRETT_SHIFT = 32;
  localparam int unsigned N_INV         = 12265;   // 512^-1 mod Q

endpackage

// File: rtl/modq_mul_barrett.sv
// Three-stage pipelined modular multiply: a*b mod Q via Barrett reduction.
// Valid and address ride alongside the data; result is combinational off the last stage.
module modq_mul_barrett #(
  parameter int unsigned ADDR_W = newhope_pkg::ADDR_W,
  parameter int unsigned Q      = newhope_pkg::Q,
  parameter int unsigned K      = newhope_pkg::BARRETT_K,
  parameter int unsigned SHIFT  = newhope_pkg::BARRETT_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [13:0]       in_a,
  input  logic [13:0]       in_b,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [13:0]       out_r
);

  logic              v1, v2, v3;
  logic [ADDR_W-1:0] ad1, ad2, ad3;
  logic [27:0]       x1, x2;
  logic [14:0]       t2;
  logic [14:0]       r3;

  // Stage 1: full 28-bit product; stage 2: Barrett quotient estimate; stage 3: remainder in [0, 2Q)
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      ad1 <= '0;
      ad2 <= '0;
      ad3 <= '0;
      x1  <= '0;
      x2  <= '0;
      t2  <= '0;
      r3  <= '0;
    end else begin
      v1  <= in_valid;
      ad1 <= in_addr;
      x1  <= 28'(in_a) * 28'(in_b);
      v2  <= v1;
      ad2 <= ad1;
      x2  <= x1;
      t2  <= 15'((47'(x1) * 47'(K)) >> SHIFT);
      v3  <= v2;
      ad3 <= ad2;
      r3  <= 15'(x2 - 28'(t2) * 28'(Q));
    end
  end

  // Final conditional subtract brings the remainder into [0, Q)
  always_comb begin
    out_valid = v3;
    out_addr  = ad3;
    out_r     = (r3 >= 15'(Q)) ? 14'(r3 - 15'(Q)) : r3[13:0];
  end

endmodule

// File: rtl/poly_pointwise_mul.sv
// Coefficient-wise c[i] = a[i]*b[i] mod Q (mode 0) or a[i]*SCALE_C mod Q (mode 1),
// streaming from two read RAMs into a result RAM with a fixed 4-cycle issue-to-write latency.
module poly_pointwise_mul #(
  parameter int unsigned N       = newhope_pkg::N,
  parameter int unsigned ADDR_W  = newhope_pkg::ADDR_W,
  parameter int unsigned DATA_W  = newhope_pkg::DATA_W,
  parameter int unsigned Q       = newhope_pkg::Q,
  parameter int unsigned SCALE_C = newhope_pkg::N_INV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rda_addr,
  input  logic [DATA_W-1:0] rda_do,
  output logic [ADDR_W-1:0] rdb_addr,
  input  logic [DATA_W-1:0] rdb_do,
  output logic              wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_di
);

  import newhope_pkg::*;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        drain_cnt;
  logic              mode_q;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [COEF_W-1:0] op_a, op_b;
  logic              unused_hi;
  logic              mul_valid;
  logic [ADDR_W-1:0] mul_addr;
  logic [COEF_W-1:0] mul_r;

  // Sequencer: issue N ascending addresses, drain the pipe, one DONE cycle.
  // A start held through DONE relaunches straight into ISSUE, so DONE is the only gap between runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      mode_q    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
    end else begin
      s1_valid <= (state == ISSUE);
      s1_addr  <= cnt;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ISSUE;
            cnt    <= '0;
            mode_q <= mode;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADDR_W'(N - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd3) state <= DONE;
        end
        default: begin
          if (start) begin
            state  <= ISSUE;
            cnt    <= '0;
            mode_q <= mode;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Operand select: upper RAM bits are ignored, scale mode substitutes the constant for B
  always_comb begin
    op_a      = rda_do[COEF_W-1:0];
    op_b      = mode_q ? COEF_W'(SCALE_C) : rdb_do[COEF_W-1:0];
    unused_hi = ^{rda_do[DATA_W-1:COEF_W], rdb_do[DATA_W-1:COEF_W]};
  end

  modq_mul_barrett #(
    .ADDR_W (ADDR_W),
    .Q      (Q),
    .K      (BARRETT_K),
    .SHIFT  (BARRETT_SHIFT)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_addr   (s1_addr),
    .in_a      (op_a),
    .in_b      (op_b),
    .out_valid (mul_valid),
    .out_addr  (mul_addr),
    .out_r     (mul_r)
  );

  // Status and write port outputs
  always_comb begin
    busy     = (state == ISSUE) || (state == DRAIN);
    done     = (state == DONE);
    rda_addr = cnt;
    rdb_addr = cnt;
    wr_we    = mul_valid;
    wr_addr  = mul_addr;
    wr_di    = DATA_W'(mul_r);
  end

endmodule
